fwd_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the fixed 5-stage hazard/forwarding logic in the MIPS pipeline.

---
 rtl/fwd_hazard_scoreboard.sv | 158 +++++++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
//
// Purpose:
//    Parametrised hazard and forwarding scoreboard for an in-order pipeline.
//    It tracks the destination tags of the instructions that have left decode
//    in a DEPTH-entry shift pipeline. Entry 0 is EX and entry DEPTH-1 is the
//    oldest tracked stage. For each decode read port it picks the forwarded
//    operand. It raises a stall when the youngest producer of a source is a
//    load whose result is not available yet.
//
// Ports:
//    i_clock         rising-edge clock
//    i_reset         synchronous, active-low reset (clears all entry valid bits)
//    i_issue_valid   decode presents an instruction this cycle
//    i_issue_we      that instruction writes a register
//    i_issue_is_load that instruction produces its result late (load)
//    i_issue_rd      destination register of the decode instruction
//    i_issue_rs      source registers, port r at [r*REG_W +: REG_W]
//    i_issue_rs_used port r actually reads its source
//    i_reg_data      register-file read data per port
//    i_stage_result  result held by entry k at [k*DATA_W +: DATA_W]
//    i_freeze        downstream hold; the tag pipeline does not move
//    i_flush         kill the instruction in decode and entry 0
//    o_stall         decode must hold (PC and IF/ID hold)
//    o_fwd_sel       per port: 0 = register file, k+1 = forwarded from entry k
//    o_fwd_data      selected operand per port
//    o_stall_cnt     (HAZ_STATS_EN only) saturating count of stall cycles
//    o_fwd_cnt       (HAZ_STATS_EN only) saturating count of forwarding cycles
//
// Configuration:
//    Define HAZ_STATS_EN to add the two saturating statistics counters and
//    their output ports. When the macro is undefined, they do not exist.

module fwd_hazard_scoreboard #(
   parameter int DATA_W     = 32,
   parameter int REG_W      = 5,
   parameter int DEPTH      = 3,
   parameter int NUM_RD     = 2,
   parameter int LOAD_STAGE = 2,
   localparam int SELW      = $clog2(DEPTH + 1)
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_issue_valid,
   input  logic                     i_issue_we,
   input  logic                     i_issue_is_load,
   input  logic [REG_W-1:0]         i_issue_rd,
   input  logic [NUM_RD*REG_W-1:0]  i_issue_rs,
   input  logic [NUM_RD-1:0]        i_issue_rs_used,
   input  logic [NUM_RD*DATA_W-1:0] i_reg_data,
   input  logic [DEPTH*DATA_W-1:0]  i_stage_result,
   input  logic                     i_freeze,
   input  logic                     i_flush,
   output logic                     o_stall,
   output logic [NUM_RD*SELW-1:0]   o_fwd_sel,
`ifdef HAZ_STATS_EN
   output logic [31:0]              o_stall_cnt,
   output logic [31:0]              o_fwd_cnt,
`endif
   output logic [NUM_RD*DATA_W-1:0] o_fwd_data
);

   // Per-entry tag state. Only the valid bits are reset. The other fields
   // are ignored while their valid bit is clear.
   logic [DEPTH-1:0] r_v;
   logic [DEPTH-1:0] r_we;
   logic [DEPTH-1:0] r_ld;
   logic [REG_W-1:0] r_rd [DEPTH];

   logic [NUM_RD-1:0] w_notReady;
   logic              w_stall;

   // Forwarding selection. The entries are scanned from oldest to youngest,
   // so the last match to be written (the lowest index) wins. A youngest
   // producer that is not ready hides any older ready copy of the same
   // register. In that case the port falls back to the register file and is
   // flagged as not ready, which leads to a stall.
   always_comb begin
      o_fwd_sel  = '0;
      o_fwd_data = i_reg_data;
      w_notReady = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_issue_rs_used[r] && (i_issue_rs[r*REG_W +: REG_W] != '0) &&
                r_v[k] && r_we[k] && (r_rd[k] == i_issue_rs[r*REG_W +: REG_W])) begin
               if (!r_ld[k] || (k >= LOAD_STAGE)) begin
                  o_fwd_sel[r*SELW +: SELW]     = SELW'(k + 1);
                  o_fwd_data[r*DATA_W +: DATA_W] = i_stage_result[k*DATA_W +: DATA_W];
                  w_notReady[r]                  = 1'b0;
               end else begin
                  o_fwd_sel[r*SELW +: SELW]     = '0;
                  o_fwd_data[r*DATA_W +: DATA_W] = i_reg_data[r*DATA_W +: DATA_W];
                  w_notReady[r]                  = 1'b1;
               end
            end
         end
      end
   end

   // A flushed decode instruction is being killed anyway, so it never stalls.
   assign w_stall = i_issue_valid & (|w_notReady) & ~i_flush;
   assign o_stall = w_stall;

   // Tag pipeline. Freeze holds every entry, but a flush during freeze still
   // kills entry 0. Otherwise the entries shift every cycle. The stage after
   // decode receives a bubble when decode is flushed or stalled, and
   // receives the decode instruction when it is issued.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_v <= '0;
      end else if (i_freeze) begin
         if (i_flush) begin
            r_v[0] <= 1'b0;
         end
      end else begin
         for (int k = 1; k < DEPTH; k++) begin
            r_v[k]  <= r_v[k-1];
            r_we[k] <= r_we[k-1];
            r_ld[k] <= r_ld[k-1];
            r_rd[k] <= r_rd[k-1];
         end
         if (i_flush || w_stall) begin
            r_v[0]  <= 1'b0;
            r_we[0] <= 1'b0;
            r_ld[0] <= 1'b0;
            r_rd[0] <= '0;
         end else begin
            r_v[0]  <= i_issue_valid;
            r_we[0] <= i_issue_we;
            r_ld[0] <= i_issue_is_load;
            r_rd[0] <= i_issue_rd;
         end
      end
   end

`ifdef HAZ_STATS_EN
   logic w_anyFwd;

   assign w_anyFwd = |o_fwd_sel;

   // Saturating statistics. Frozen cycles are not counted. A forwarding
   // cycle is counted only when the decode instruction actually proceeds.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         o_stall_cnt <= '0;
         o_fwd_cnt   <= '0;
      end else begin
         if (w_stall && !i_freeze && (o_stall_cnt != 32'hFFFF_FFFF)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
         end
         if (w_anyFwd && !w_stall && !i_freeze && (o_fwd_cnt != 32'hFFFF_FFFF)) begin
            o_fwd_cnt <= o_fwd_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard
//
// Directed scenarios for fwd_hazard_scoreboard at its default parameters.
// Inputs change on the falling edge, and outputs are compared 1 time unit
// later. The expected values are written out by hand for each step.

module tb_fwd_hazard_scoreboard;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int DEPTH  = 3;
   localparam int NUM_RD = 2;
   localparam int SELW   = 2;

   logic                     i_clock = 1'b0;
   logic                     i_reset;
   logic                     i_issue_valid;
   logic                     i_issue_we;
   logic                     i_issue_is_load;
   logic [REG_W-1:0]         i_issue_rd;
   logic [NUM_RD*REG_W-1:0]  i_issue_rs;
   logic [NUM_RD-1:0]        i_issue_rs_used;
   logic [NUM_RD*DATA_W-1:0] i_reg_data;
   logic [DEPTH*DATA_W-1:0]  i_stage_result;
   logic                     i_freeze;
   logic                     i_flush;
   logic                     o_stall;
   logic [NUM_RD*SELW-1:0]   o_fwd_sel;
   logic [NUM_RD*DATA_W-1:0] o_fwd_data;
`ifdef HAZ_STATS_EN
   logic [31:0]              o_stall_cnt;
   logic [31:0]              o_fwd_cnt;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   localparam logic [DATA_W-1:0] SR0 = 32'h0000_1234;
   localparam logic [DATA_W-1:0] SR1 = 32'hBBBB_0001;
   localparam logic [DATA_W-1:0] SR2 = 32'hCCCC_0002;
   localparam logic [DATA_W-1:0] RD0 = 32'hAAAA_0000;
   localparam logic [DATA_W-1:0] RD1 = 32'hAAAA_1111;

   fwd_hazard_scoreboard dut (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_issue_valid   (i_issue_valid),
      .i_issue_we      (i_issue_we),
      .i_issue_is_load (i_issue_is_load),
      .i_issue_rd      (i_issue_rd),
      .i_issue_rs      (i_issue_rs),
      .i_issue_rs_used (i_issue_rs_used),
      .i_reg_data      (i_reg_data),
      .i_stage_result  (i_stage_result),
      .i_freeze        (i_freeze),
      .i_flush         (i_flush),
      .o_stall         (o_stall),
      .o_fwd_sel       (o_fwd_sel),
`ifdef HAZ_STATS_EN
      .o_stall_cnt     (o_stall_cnt),
      .o_fwd_cnt       (o_fwd_cnt),
`endif
      .o_fwd_data      (o_fwd_data)
   );

   always #5 i_clock = ~i_clock;

   // Drives one decode cycle on the falling edge and then leaves time for
   // the combinational outputs to settle before the caller compares them.
   task automatic applyStimulus(input logic valid, input logic we, input logic ld,
                                input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs0,
                                input logic [REG_W-1:0] rs1, input logic [1:0] used,
                                input logic frz, input logic fl);
      @(negedge i_clock);
      i_issue_valid   = valid;
      i_issue_we      = we;
      i_issue_is_load = ld;
      i_issue_rd      = rd;
      i_issue_rs      = {rs1, rs0};
      i_issue_rs_used = used;
      i_freeze        = frz;
      i_flush         = fl;
      #1;
   endtask

   task automatic test_reset();
      logic [REG_W-1:0]  rs0, rs1;
      logic [DATA_W-1:0] d0, d1;
      @(negedge i_clock);
      i_reset = 1'b0;
      repeat (2) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
      #1;
      testsRun++;
      if (o_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %b want 0", o_stall); end
      testsRun++;
      if (o_fwd_sel !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_sel: got %h want 0", o_fwd_sel); end
      // Non-writing instructions fill the pipeline. They must never match.
      for (int i = 0; i < 8; i++) begin
         rs0 = REG_W'($urandom_range(1, 31));
         rs1 = REG_W'($urandom_range(1, 31));
         d0  = $urandom;
         d1  = $urandom;
         i_reg_data = {d1, d0};
         applyStimulus(1'b1, 1'b0, 1'b0, rs0, rs0, rs1, 2'b11, 1'b0, 1'b0);
         testsRun++;
         if (o_stall !== 1'b0 || o_fwd_sel !== 4'b0000) begin
            testsFailed++; $display("[TB] FAIL reset_rand%0d: stall=%b sel=%h want 0/0", i, o_stall, o_fwd_sel);
         end
         testsRun++;
         if (o_fwd_data !== {d1, d0}) begin
            testsFailed++; $display("[TB] FAIL reset_data%0d: got %h want %h", i, o_fwd_data, {d1, d0});
         end
      end
      i_reg_data = {RD1, RD0};
   endtask

   task automatic test_alu_forward();
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL alu_issue_stall: got %b want 0", o_stall); end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b11, 1'b0, 1'b0);
      testsRun++;
      if (o_fwd_sel[1:0] !== 2'd1 || o_fwd_data[31:0] !== SR0 || o_stall !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL alu_e0: sel=%0d data=%h stall=%b want 1/%h/0", o_fwd_sel[1:0], o_fwd_data[31:0], o_stall, SR0);
      end
      testsRun++;
      if (o_fwd_sel[3:2] !== 2'd0 || o_fwd_data[63:32] !== RD1) begin
         testsFailed++; $display("[TB] FAIL alu_r0port: sel=%0d data=%h want 0/%h", o_fwd_sel[3:2], o_fwd_data[63:32], RD1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_fwd_sel !== {2'd0, 2'd2} || o_fwd_data[31:0] !== SR1) begin
         testsFailed++; $display("[TB] FAIL alu_e1: sel=%h data=%h want 2/%h", o_fwd_sel, o_fwd_data[31:0], SR1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_fwd_sel[1:0] !== 2'd3 || o_fwd_data[31:0] !== SR2) begin
         testsFailed++; $display("[TB] FAIL alu_e2: sel=%0d data=%h want 3/%h", o_fwd_sel[1:0], o_fwd_data[31:0], SR2);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_fwd_sel[1:0] !== 2'd0 || o_fwd_data[31:0] !== RD0) begin
         testsFailed++; $display("[TB] FAIL alu_dropped: sel=%0d data=%h want 0/%h", o_fwd_sel[1:0], o_fwd_data[31:0], RD0);
      end
   endtask

   task automatic test_load_use();
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 2'b10, 1'b0, 1'b0);
         testsRun++;
         if (o_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL load_stall%0d: got %b want 1", c, o_stall); end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 2'b10, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b0 || o_fwd_sel[3:2] !== 2'd3 || o_fwd_data[63:32] !== SR2) begin
         testsFailed++; $display("[TB] FAIL load_resolve: stall=%b sel=%0d data=%h want 0/3/%h", o_stall, o_fwd_sel[3:2], o_fwd_data[63:32], SR2);
      end
   endtask

   task automatic test_youngest();
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_fwd_sel[1:0] !== 2'd1 || o_fwd_data[31:0] !== SR0 || o_stall !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL youngest_alu: sel=%0d data=%h stall=%b want 1/%h/0", o_fwd_sel[1:0], o_fwd_data[31:0], o_stall, SR0);
      end
      // The older ALU copy is ready, but the younger load hides it.
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b01, 1'b0, 1'b0);
         testsRun++;
         if (o_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL youngest_load_stall%0d: got %b want 1", c, o_stall); end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b0 || o_fwd_sel[1:0] !== 2'd3) begin
         testsFailed++; $display("[TB] FAIL youngest_load_resolve: stall=%b sel=%0d want 0/3", o_stall, o_fwd_sel[1:0]);
      end
   endtask

   task automatic test_reg_zero_flush();
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0);
      testsRun++;
      if (o_fwd_sel !== 4'b0000 || o_fwd_data !== {RD1, RD0} || o_stall !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reg_zero: sel=%h data=%h stall=%b want 0/%h/0", o_fwd_sel, o_fwd_data, o_stall, {RD1, RD0});
      end
      // A load that is flushed in decode must never enter the pipeline.
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b0 || o_fwd_sel[1:0] !== 2'd0) begin
         testsFailed++; $display("[TB] FAIL flush_decode: stall=%b sel=%0d want 0/0", o_stall, o_fwd_sel[1:0]);
      end
      // The flush masks the stall, but the load still shifts onward.
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0, 2'b01, 1'b0, 1'b1);
      testsRun++;
      if (o_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_mask: got %b want 0", o_stall); end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_shift: got %b want 1", o_stall); end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b0 || o_fwd_sel[1:0] !== 2'd3) begin
         testsFailed++; $display("[TB] FAIL flush_resolve: stall=%b sel=%0d want 0/3", o_stall, o_fwd_sel[1:0]);
      end
   endtask

   task automatic test_freeze();
      @(negedge i_clock);
      i_reset = 1'b0;
      @(negedge i_clock);
      i_reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 2'b10, 1'b1, 1'b0);
         testsRun++;
         if (o_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL freeze_hold%0d: got %b want 1", c, o_stall); end
      end
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 2'b10, 1'b0, 1'b0);
         testsRun++;
         if (o_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL freeze_release%0d: got %b want 1", c, o_stall); end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 2'b10, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b0 || o_fwd_sel[3:2] !== 2'd3 || o_fwd_data[63:32] !== SR2) begin
         testsFailed++; $display("[TB] FAIL freeze_resolve: stall=%b sel=%0d data=%h want 0/3/%h", o_stall, o_fwd_sel[3:2], o_fwd_data[63:32], SR2);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
`ifdef HAZ_STATS_EN
      testsRun++;
      if (o_stall_cnt !== 32'd2) begin testsFailed++; $display("[TB] FAIL stall_cnt: got %0d want 2", o_stall_cnt); end
      testsRun++;
      if (o_fwd_cnt !== 32'd1) begin testsFailed++; $display("[TB] FAIL fwd_cnt: got %0d want 1", o_fwd_cnt); end
`endif
      // A flush during freeze still kills entry 0.
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd11, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 5'd0, 2'b01, 1'b1, 1'b1);
      testsRun++;
      if (o_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL freeze_flush_mask: got %b want 0", o_stall); end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 5'd0, 2'b01, 1'b0, 1'b0);
      testsRun++;
      if (o_stall !== 1'b0 || o_fwd_sel[1:0] !== 2'd0) begin
         testsFailed++; $display("[TB] FAIL freeze_flush_kill: stall=%b sel=%0d want 0/0", o_stall, o_fwd_sel[1:0]);
      end
   endtask

   initial begin
      i_reset         = 1'b1;
      i_issue_valid   = 1'b0;
      i_issue_we      = 1'b0;
      i_issue_is_load = 1'b0;
      i_issue_rd      = '0;
      i_issue_rs      = '0;
      i_issue_rs_used = '0;
      i_reg_data      = {RD1, RD0};
      i_stage_result  = {SR2, SR1, SR0};
      i_freeze        = 1'b0;
      i_flush         = 1'b0;
      test_reset();
      test_alu_forward();
      test_load_use();
      test_youngest();
      test_reg_zero_flush();
      test_freeze();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not reach the end");
      $fatal(1, "[TB] timeout");
   end

endmodule
